// File: rtl/evm_pkg.sv
// Shared definitions for the EVM ballot front end and the vote counter.
package evm_pkg;

  // Party codes carried on incr_party_vote; button bit i maps to party i+1.
  localparam logic [1:0] PARTY1 = 2'b00;
  localparam logic [1:0] PARTY2 = 2'b01;
  localparam logic [1:0] PARTY3 = 2'b10;
  localparam logic [1:0] PARTY4 = 2'b11;

  // Poll size shared with the counter block; voters_cast is 6 bits, so at most 63.
  localparam int TOTAL_VOTER_DEFAULT = 31;

  // Ballot sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    CAST  = 2'b10,
    LOCK  = 2'b11
  } ballot_state_e;

  // Number of buttons currently reading as pressed.
  function automatic logic [2:0] active_count(input logic [3:0] b);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, b[i]};
    end
    return n;
  endfunction

  // Party code of a single pressed button; only meaningful when exactly one bit is set.
  function automatic logic [1:0] party_code(input logic [3:0] b);
    logic [1:0] c;
    c = PARTY1;
    case (b)
      4'b0001: c = PARTY1;
      4'b0010: c = PARTY2;
      4'b0100: c = PARTY3;
      4'b1000: c = PARTY4;
      default: c = PARTY1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/evm_debounce.sv
// Single-button debouncer: the clean output follows the raw input only after
// DEBOUNCE_CYCLES consecutive samples that differ from the current clean value.
module evm_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic debounced
);

  // Counter only has to reach DEBOUNCE_CYCLES-1 before the clean value flips.
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          db_q;
  logic          db_d;

  // Count disagreeing samples; any agreeing sample restarts the run.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (raw != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = raw;
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // Debounce state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CNT_ZERO;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign debounced = db_q;

endmodule

// File: rtl/evm_ballot_unit.sv
// Voter-facing ballot front end: one armed ballot accepts exactly one clean
// single-button press and emits it as a one-cycle vote strobe for the counter.
module evm_ballot_unit
  import evm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int TOTAL_VOTER     = TOTAL_VOTER_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       control,
  input  logic [3:0] button,
  output logic       vote_valid,
  output logic [1:0] incr_party_vote,
  output logic       armed,
  output logic [5:0] voters_cast,
  output logic       poll_closed,
  output logic       invalid_press,
  output logic       timeout
);

  // Timer counts 0..TIMEOUT_CYCLES-1 while ARMED.
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
  localparam logic [5:0]    VOTER_MAX  = 6'(TOTAL_VOTER);

  logic [3:0]    button_db;
  logic [2:0]    n_active;

  ballot_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    code_q, code_d;
  logic          multi_q, multi_d;
  logic          control_q, control_d;
  logic          arm_edge_q, arm_edge_d;

  logic          vote_valid_q, vote_valid_d;
  logic [1:0]    incr_q, incr_d;
  logic          armed_q, armed_d;
  logic [5:0]    voters_q, voters_d;
  logic          poll_q, poll_d;
  logic          invalid_q, invalid_d;
  logic          timeout_q, timeout_d;

  for (genvar i = 0; i < 4; i++) begin : g_debounce
    evm_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .raw      (button[i]),
      .debounced(button_db[i])
    );
  end

  assign n_active = active_count(button_db);

  // Arm-button rising-edge detection; the edge is registered before the FSM sees it.
  always_comb begin
    control_d  = control;
    arm_edge_d = control & ~control_q;
  end

  // Ballot sequencing: next state, timer, latched party code and event strobes.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    code_d    = code_q;
    multi_d   = 1'b0;
    invalid_d = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = TIMER_ZERO;
        if (arm_edge_q && mode && !poll_q && (button_db == 4'b0000)) begin
          state_d = ARMED;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        multi_d = (n_active > 3'd1);
        if (!mode) begin
          // Leaving voting mode silently abandons the ballot.
          state_d = IDLE;
          timer_d = TIMER_ZERO;
        end else if (n_active == 3'd1) begin
          // A valid press beats a timer that expires in the same cycle.
          state_d = CAST;
          code_d  = party_code(button_db);
          timer_d = TIMER_ZERO;
        end else begin
          // One invalid strobe per multi-press episode; the timer keeps running.
          if (multi_d && !multi_q) begin
            invalid_d = 1'b1;
          end else begin
            invalid_d = 1'b0;
          end
          if (timer_q == TIMER_LAST) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
            timer_d   = TIMER_ZERO;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end
      end
      CAST: begin
        state_d = LOCK;
      end
      LOCK: begin
        // Held buttons must be fully released before another ballot can be armed.
        if (button_db == 4'b0000) begin
          state_d = IDLE;
        end else begin
          state_d = LOCK;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = TIMER_ZERO;
      end
    endcase
  end

  // Registered outputs: vote strobe follows the CAST state, count saturates, poll closure is sticky.
  always_comb begin
    vote_valid_d = (state_q == CAST);
    armed_d      = (state_d == ARMED);
    poll_d       = poll_q | (voters_q >= VOTER_MAX);
    if (state_q == CAST) begin
      incr_d = code_q;
    end else begin
      incr_d = incr_q;
    end
    if ((state_q == CAST) && (voters_q < VOTER_MAX)) begin
      voters_d = voters_q + 6'd1;
    end else begin
      voters_d = voters_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= TIMER_ZERO;
      code_q       <= PARTY1;
      multi_q      <= 1'b0;
      control_q    <= 1'b0;
      arm_edge_q   <= 1'b0;
      vote_valid_q <= 1'b0;
      incr_q       <= PARTY1;
      armed_q      <= 1'b0;
      voters_q     <= 6'd0;
      poll_q       <= 1'b0;
      invalid_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      code_q       <= code_d;
      multi_q      <= multi_d;
      control_q    <= control_d;
      arm_edge_q   <= arm_edge_d;
      vote_valid_q <= vote_valid_d;
      incr_q       <= incr_d;
      armed_q      <= armed_d;
      voters_q     <= voters_d;
      poll_q       <= poll_d;
      invalid_q    <= invalid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign vote_valid      = vote_valid_q;
  assign incr_party_vote = incr_q;
  assign armed           = armed_q;
  assign voters_cast     = voters_q;
  assign poll_closed     = poll_q;
  assign invalid_press   = invalid_q;
  assign timeout         = timeout_q;

endmodule

// File: tb/tb_evm_ballot_unit.sv
// Self-checking bench for evm_ballot_unit (DEBOUNCE=4, TIMEOUT=8, TOTAL_VOTER=3).
module tb_evm_ballot_unit;

  localparam int DEB = 4;
  localparam int TMO = 8;
  localparam int TOT = 3;
  localparam int PRESS_TO_VOTE = DEB + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic       control;
  logic [3:0] button;
  logic       vote_valid;
  logic [1:0] incr_party_vote;
  logic       armed;
  logic [5:0] voters_cast;
  logic       poll_closed;
  logic       invalid_press;
  logic       timeout;

  int vectors = 0;
  int errors  = 0;
  int model_cast = 0;

  always #5 clk = ~clk;

  evm_ballot_unit #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO),
    .TOTAL_VOTER    (TOT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mode           (mode),
    .control        (control),
    .button         (button),
    .vote_valid     (vote_valid),
    .incr_party_vote(incr_party_vote),
    .armed          (armed),
    .voters_cast    (voters_cast),
    .poll_closed    (poll_closed),
    .invalid_press  (invalid_press),
    .timeout        (timeout)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_control();
    control = 1'b1;
    tick();
    control = 1'b0;
  endtask

  // Ticks until armed is seen (bounded); returns tick index or -1.
  task automatic wait_armed(output int at);
    at = -1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (armed && at < 0) at = i;
      if (at >= 0) break;
    end
  endtask

  // Monitor events over n ticks; indices are 1-based tick numbers within the window.
  task automatic observe(input int n, output int vv_cnt, output int vv_at, output logic [1:0] code,
                         output int to_at, output int inv_cnt, output int armed_hi);
    vv_cnt = 0; vv_at = -1; code = 2'b00; to_at = -1; inv_cnt = 0; armed_hi = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (vote_valid) begin
        vv_cnt++;
        if (vv_at < 0) begin
          vv_at = i;
          code = incr_party_vote;
        end
      end
      if (timeout && to_at < 0) to_at = i;
      if (invalid_press) inv_cnt++;
      if (armed) armed_hi++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 1'b0; control = 1'b0; button = 4'b0000;
    tick(); tick();
    vectors++;
    if ({vote_valid, incr_party_vote, armed, voters_cast, poll_closed, invalid_press, timeout} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got vv=%b code=%b armed=%b cast=%0d closed=%b inv=%b to=%b expected all 0",
               vote_valid, incr_party_vote, armed, voters_cast, poll_closed, invalid_press, timeout);
    end
    reset = 1'b0;
    model_cast = 0;
  endtask

  task automatic test_basic_vote();
    int at, vc, va, ta, ic, ah; logic [1:0] cd;
    mode = 1'b1;
    pulse_control();
    wait_armed(at);
    vectors++;
    if (at !== 1) begin errors++; $display("FAIL basic_arm: armed after %0d ticks expected 1", at); end
    button = 4'b0100;
    observe(10, vc, va, cd, ta, ic, ah);
    button = 4'b0000;
    model_cast++;
    vectors++;
    if (va !== PRESS_TO_VOTE) begin errors++; $display("FAIL basic_latency: vote at %0d expected %0d", va, PRESS_TO_VOTE); end
    vectors++;
    if (vc !== 1) begin errors++; $display("FAIL basic_count: %0d votes expected 1", vc); end
    vectors++;
    if (cd !== 2'b10) begin errors++; $display("FAIL basic_code: got %b expected 10", cd); end
    vectors++;
    if (voters_cast !== 6'(model_cast)) begin errors++; $display("FAIL basic_cast: got %0d expected %0d", voters_cast, model_cast); end
    observe(8, vc, va, cd, ta, ic, ah);
  endtask

  task automatic test_held_button();
    int at, vc, va, ta, ic, ah; logic [1:0] cd;
    pulse_control();
    wait_armed(at);
    button = 4'b0001;
    observe(8, vc, va, cd, ta, ic, ah);
    model_cast++;
    vectors++;
    if (vc !== 1 || cd !== 2'b00) begin errors++; $display("FAIL held_first: votes=%0d code=%b expected 1/00", vc, cd); end
    pulse_control();
    observe(41, vc, va, cd, ta, ic, ah);
    vectors++;
    if (vc !== 0 || ah !== 0) begin errors++; $display("FAIL held_lock: votes=%0d armed_cycles=%0d expected 0/0", vc, ah); end
    button = 4'b0000;
    observe(10, vc, va, cd, ta, ic, ah);
    vectors++;
    if (ah !== 0) begin errors++; $display("FAIL held_discard: armed_cycles=%0d expected 0", ah); end
    vectors++;
    if (voters_cast !== 6'(model_cast)) begin errors++; $display("FAIL held_cast: got %0d expected %0d", voters_cast, model_cast); end
  endtask

  task automatic test_timeout();
    int at, vc, va, ta, ic, ah; logic [1:0] cd;
    pulse_control();
    wait_armed(at);
    observe(10, vc, va, cd, ta, ic, ah);
    vectors++;
    if (ta !== TMO) begin errors++; $display("FAIL timeout_at: pulse at %0d expected %0d", ta, TMO); end
    vectors++;
    if (ah !== TMO - 1 || vc !== 0) begin errors++; $display("FAIL timeout_armed: armed_cycles=%0d votes=%0d expected %0d/0", ah, vc, TMO - 1); end
    vectors++;
    if (voters_cast !== 6'(model_cast)) begin errors++; $display("FAIL timeout_cast: got %0d expected %0d", voters_cast, model_cast); end
    pulse_control();
    wait_armed(at);
    observe(2, vc, va, cd, ta, ic, ah);
    mode = 1'b0;
    observe(10, vc, va, cd, ta, ic, ah);
    vectors++;
    if (ah !== 0 || ta !== -1) begin errors++; $display("FAIL mode_drop: armed_cycles=%0d timeout_at=%0d expected 0/-1", ah, ta); end
    mode = 1'b1;
  endtask

  task automatic test_invalid_then_vote();
    int at, vc, va, ta, ic, ah; logic [1:0] cd;
    pulse_control();
    wait_armed(at);
    button = 4'b0011;
    observe(7, vc, va, cd, ta, ic, ah);
    vectors++;
    if (ic !== 1 || vc !== 0) begin errors++; $display("FAIL invalid_pulse: pulses=%0d votes=%0d expected 1/0", ic, vc); end
    button = 4'b0000;
    observe(8, vc, va, cd, ta, ic, ah);
    vectors++;
    if (ta !== 1 || ah !== 0) begin errors++; $display("FAIL invalid_timer: timeout_at=%0d armed_cycles=%0d expected 1/0", ta, ah); end
    pulse_control();
    wait_armed(at);
    button = 4'b0010;
    observe(8, vc, va, cd, ta, ic, ah);
    model_cast++;
    vectors++;
    if (va !== PRESS_TO_VOTE || cd !== 2'b01) begin errors++; $display("FAIL second_press: vote_at=%0d code=%b expected %0d/01", va, cd, PRESS_TO_VOTE); end
    vectors++;
    if (voters_cast !== 6'(model_cast) || poll_closed !== (model_cast == TOT)) begin
      errors++; $display("FAIL close_flag: cast=%0d closed=%b expected %0d/%b", voters_cast, poll_closed, model_cast, model_cast == TOT);
    end
    button = 4'b0000;
    observe(8, vc, va, cd, ta, ic, ah);
  endtask

  task automatic test_poll_closed();
    int vc, va, ta, ic, ah; logic [1:0] cd;
    pulse_control();
    observe(10, vc, va, cd, ta, ic, ah);
    vectors++;
    if (ah !== 0 || vc !== 0) begin errors++; $display("FAIL closed_arm: armed_cycles=%0d votes=%0d expected 0/0", ah, vc); end
    vectors++;
    if (voters_cast !== 6'(TOT) || poll_closed !== 1'b1) begin errors++; $display("FAIL closed_state: cast=%0d closed=%b expected %0d/1", voters_cast, poll_closed, TOT); end
  endtask

  task automatic test_reset_midway();
    int at, vc, va, ta, ic, ah; logic [1:0] cd;
    reset = 1'b1; tick(); reset = 1'b0;
    model_cast = 0;
    pulse_control();
    wait_armed(at);
    button = 4'b0001;
    observe(4, vc, va, cd, ta, ic, ah);
    reset = 1'b1;
    tick();
    vectors++;
    if ({vote_valid, incr_party_vote, armed, voters_cast, poll_closed, invalid_press, timeout} !== 13'd0) begin
      errors++;
      $display("FAIL midway_reset: got vv=%b armed=%b cast=%0d closed=%b expected all 0", vote_valid, armed, voters_cast, poll_closed);
    end
    reset = 1'b0;
    observe(10, vc, va, cd, ta, ic, ah);
    vectors++;
    if (vc !== 0 || ah !== 0) begin errors++; $display("FAIL midway_dropped: votes=%0d armed_cycles=%0d expected 0/0", vc, ah); end
    button = 4'b0000;
    observe(8, vc, va, cd, ta, ic, ah);
    mode = 1'b0;
    pulse_control();
    observe(6, vc, va, cd, ta, ic, ah);
    vectors++;
    if (ah !== 0) begin errors++; $display("FAIL result_mode_arm: armed_cycles=%0d expected 0", ah); end
    mode = 1'b1;
  endtask

  // Random party and press delay; a press reaches the FSM DEB+1 ticks after it is driven,
  // so it wins only if it arrives no later than the final armed cycle.
  task automatic test_random();
    int at, vc, va, ta, ic, ah, w, p; logic [1:0] cd; bit expect_vote;
    reset = 1'b1; tick(); reset = 1'b0;
    model_cast = 0;
    for (int it = 0; it < 12; it++) begin
      if (model_cast == TOT) begin
        pulse_control();
        observe(8, vc, va, cd, ta, ic, ah);
        vectors++;
        if (ah !== 0 || vc !== 0 || poll_closed !== 1'b1) begin
          errors++; $display("FAIL rand_closed: armed_cycles=%0d votes=%0d closed=%b expected 0/0/1", ah, vc, poll_closed);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        model_cast = 0;
        continue;
      end
      w = $urandom_range(0, 6);
      p = $urandom_range(0, 3);
      pulse_control();
      wait_armed(at);
      vectors++;
      if (at !== 1) begin errors++; $display("FAIL rand_arm: armed after %0d expected 1", at); end
      if (w > 0) observe(w, vc, va, cd, ta, ic, ah);
      button = 4'b0001 << p;
      observe(12, vc, va, cd, ta, ic, ah);
      expect_vote = (w + DEB + 1 <= TMO);
      if (expect_vote) begin
        model_cast++;
        vectors++;
        if (vc !== 1 || va !== PRESS_TO_VOTE || cd !== 2'(p) || ta !== -1) begin
          errors++; $display("FAIL rand_vote: w=%0d votes=%0d at=%0d code=%b to=%0d expected 1/%0d/%0d/-1", w, vc, va, cd, ta, PRESS_TO_VOTE, p);
        end
      end else begin
        vectors++;
        if (vc !== 0 || ta !== TMO - w) begin
          errors++; $display("FAIL rand_timeout: w=%0d votes=%0d to=%0d expected 0/%0d", w, vc, ta, TMO - w);
        end
      end
      vectors++;
      if (voters_cast !== 6'(model_cast) || poll_closed !== (model_cast == TOT)) begin
        errors++; $display("FAIL rand_count: cast=%0d closed=%b expected %0d/%b", voters_cast, poll_closed, model_cast, model_cast == TOT);
      end
      button = 4'b0000;
      observe(8, vc, va, cd, ta, ic, ah);
    end
  endtask

  initial begin
    test_reset();
    test_basic_vote();
    test_held_button();
    test_timeout();
    test_invalid_then_vote();
    test_poll_closed();
    test_reset_midway();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/evm_ballot_unit.md
Name: evm_ballot_unit

Overview:
- Voter-facing front end of the EVM: turns raw party push-buttons into clean, one-per-voter vote events on incr_party_vote/vote_valid for the vote counter.
- Presiding officer arms one ballot with control; exactly one debounced single-button press is accepted per arming.
- Enforces voter limit, arming timeout and multi-press rejection.
- Sits between panel I/O and the counter block.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles before a button change is accepted (>=1).
- TIMEOUT_CYCLES, 255, cycles ARMED may wait for a press before disarming.
- TOTAL_VOTER, 31, maximum ballots cast before the poll closes.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  1 = voting mode, 0 = result mode; ballots accepted only when 1.
- control  in  1  officer arm button, level input, rising edge arms one ballot.
- button  in  4  raw party buttons, bit i = party i+1.
- vote_valid  out  1  one-cycle strobe: incr_party_vote carries a vote.
- incr_party_vote  out  2  party code 00..11, valid with vote_valid, held otherwise.
- armed  out  1  ballot-ready lamp, high in ARMED.
- voters_cast  out  6  ballots cast since reset, saturates at TOTAL_VOTER.
- poll_closed  out  1  high once voters_cast == TOTAL_VOTER.
- invalid_press  out  1  one-cycle strobe: more than one debounced button active while ARMED.
- timeout  out  1  one-cycle strobe: ARMED expired without a vote.

Behaviour:
- Reset values, clk edge with reset=1: all outputs 0, incr_party_vote=00, state IDLE, debounced buttons 0, control edge register 0, timers 0.
- Debounce, per button: the debounced bit takes the raw value after DEBOUNCE_CYCLES consecutive equal samples. Any mismatch restarts the count.
- Arm edge: control rising edge = control & ~control_q, registered, no debounce.

States:
- IDLE: go to ARMED when arm edge & mode & ~poll_closed & all debounced buttons 0. Otherwise stay; the arm edge is discarded.
- ARMED: armed=1, timer increments.
  - Exactly one debounced button active: go to CAST, latch its code.
  - More than one active: invalid_press pulse, stay ARMED, timer not reset.
  - Timer == TIMEOUT_CYCLES-1 with no valid press: timeout pulse, go to IDLE.
  - mode falls to 0: go to IDLE without a pulse.
  - A valid press in the same cycle as expiry wins: CAST, no timeout pulse.
- CAST: exactly one cycle.
  - vote_valid=1, incr_party_vote=latched code, voters_cast+1.
  - poll_closed rises on the next cycle if the new count == TOTAL_VOTER.
  - Go to LOCK.
- LOCK: wait until all debounced buttons are 0, then go to IDLE. Arm edges while in LOCK are discarded; a held button never casts a second vote.
- Latency: debounced press to vote_valid = 2 cycles (ARMED detect, CAST output). Raw press to vote_valid = DEBOUNCE_CYCLES+2.
- vote_valid never asserts outside CAST. At most one vote_valid per arm edge.
- poll_closed is sticky until reset. voters_cast never exceeds TOTAL_VOTER; it has 6 bits so TOTAL_VOTER may go up to 63.
- Reset mid-operation (any state) returns to IDLE the next cycle. A pending vote is dropped, no vote_valid.
- Downstream counter contract: the counter must increment only on vote_valid. It must not increment on incr_party_vote alone, because the idle value 00 would otherwise count for party 1.

Decomposition:
- Shared package evm_pkg:
  - party code constants PARTY1..PARTY4 = 2'b00..2'b11.
  - ballot state encoding IDLE/ARMED/CAST/LOCK.
  - default TOTAL_VOTER, shared with the counter.
- One sub-module, evm_debounce, parameterised by DEBOUNCE_CYCLES. It handles a single button, is instantiated 4×, and uses the same clk/reset.

Test Plan:
- Reset, then mode=1, control pulse, button=0100 held 10 cycles (DEBOUNCE_CYCLES=4) -> armed=1; one vote_valid with incr_party_vote=10 exactly 6 cycles after the press; voters_cast=1.
- Button=0001 held 50 cycles after a cast, plus a second control pulse during the hold -> no further vote_valid; state stays LOCK until release.
- Armed, button=0011 pressed -> invalid_press pulse, no vote. Release, then press 0010 -> vote_valid, incr_party_vote=01.
- Armed with TIMEOUT_CYCLES=8 and no press -> timeout pulse exactly 8 cycles after armed rises, armed=0, voters_cast unchanged.
- TOTAL_VOTER=3, cast 3 votes -> poll_closed=1 after the third; a 4th control pulse leaves armed=0 and produces no vote_valid.
- Reset asserted during ARMED with a press in progress -> next cycle all outputs 0, IDLE, no vote_valid; mode=0 with a control pulse -> no arming.
